// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo: output stage downstream of the FIR filter.
//   Keeps every DECIM-th valid input sample and buffers the kept samples in a
//   DEPTH-entry first-word-fall-through FIFO. A valid/ready handshake drains it.
//   If a kept sample arrives while the FIFO is full and no pop happens, the
//   sample is dropped and a sticky overflow flag is set.
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high; clears the FIFO, the phase and overflow
//   in_data    N-bit sample from the FIR
//   in_valid   in_data carries a new sample this cycle
//   out_data   head-of-FIFO sample, meaningful only while out_valid=1
//   out_valid  FIFO not empty (registered)
//   out_ready  consumer takes out_data this cycle
//   level      number of stored entries, 0..DEPTH
//   overflow   sticky: at least one kept sample was dropped since reset
module fir_decim_fifo #(
  parameter int N     = 16,
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           in_data,
  input  logic                   in_valid,
  output logic [N-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  // The phase counter needs at least one bit. For DECIM=1 it stays at 0.
  localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [N-1:0]   mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PHW-1:0] phase;
  logic           keep, full, pop, push;
  logic [LW-1:0]  level_nxt;

  assign keep      = in_valid && (phase == '0);
  assign full      = (level == LW'(DEPTH));
  assign pop       = out_valid && out_ready;
  // When the FIFO is full, a pop in the same cycle frees the slot the push needs.
  assign push      = keep && (!full || pop);
  assign level_nxt = level + LW'(push) - LW'(pop);
  assign out_data  = mem[rd_ptr];

  // Storage has no reset. A stored word is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (in_valid)
        phase <= (phase == PHW'(DECIM - 1)) ? '0 : phase + 1'b1;
      // DEPTH is a power of two, so the pointers wrap by simple overflow.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      if (keep && full && !pop) overflow <= 1'b1;
    end
  end
endmodule
